// File: rtl/adc_axis_packetizer.sv
// ---------------------------------------------------------------------------
// adc_axis_packetizer
//   Packs 16-bit ADC samples into 32-bit AXI4-Stream words ({odd, even}) and
//   emits one packet of a software-programmed byte length per start pulse.
//   Words pass through a FIFO and a registered AXIS output stage.
//
// Build option:
//   ADC_TEST_PATTERN_EN - adds input test_mode; when high, samples come from
//                         an internal 16-bit counter restarted on each start.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   sample_data/_valid  ADC sample input (clk domain)
//   test_mode           (ADC_TEST_PATTERN_EN only) select counter samples
//   start, packet_size  begin a packet of packet_size bytes (bits [1:0] ignored)
//   busy, done          packet in progress / one-cycle completion pulse
//   overflow            sticky: a word was dropped on FIFO full
//   m_axis_*            AXI4-Stream master (tkeep fixed at 4'hF)
// ---------------------------------------------------------------------------
module adc_axis_packetizer #(
  parameter int FIFO_DEPTH = 512,
  parameter int SIZE_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           sample_data,
  input  logic                  sample_valid,
`ifdef ADC_TEST_PATTERN_EN
  input  logic                  test_mode,
`endif
  input  logic                  start,
  input  logic [SIZE_WIDTH-1:0] packet_size,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [31:0]           m_axis_tdata,
  output logic [3:0]            m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = SIZE_WIDTH - 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            w_busy;

  logic [CW-1:0]   r_size_words;
  logic [CW-1:0]   r_word_cnt;
  logic [CW-1:0]   w_cnt_inc;
  logic            r_phase;
  logic [15:0]     r_low;
  logic            r_overflow;
  logic            r_done;

  logic [32:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic [31:0]     r_tdata;
  logic            r_tlast;
  logic            r_tvalid;

  logic [15:0]     w_sample;
  logic            w_start_ok;
  logic            w_capture;
  logic            w_push_try;
  logic            w_push;
  logic            w_drop;
  logic            w_full;
  logic            w_fifo_rd;
  logic            w_is_last;
  logic            w_last_hs;
  logic            w_unused_bits;

  // Byte-granular size: the two low bits cannot form a whole word.
  assign w_unused_bits = ^packet_size[1:0];

`ifdef ADC_TEST_PATTERN_EN
  logic [15:0] r_pat;

  // Test-pattern counter: restarts on each accepted start, advances per captured sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat <= 16'd0;
    end else if (w_start_ok) begin
      r_pat <= 16'd0;
    end else if (w_capture) begin
      r_pat <= r_pat + 16'd1;
    end
  end

  assign w_sample = test_mode ? r_pat : sample_data;
`else
  assign w_sample = sample_data;
`endif

  assign w_start_ok = start && (r_state == S_IDLE) && (packet_size[SIZE_WIDTH-1:2] != {CW{1'b0}});
  assign w_capture  = (r_state == S_CAPTURE) && sample_valid;
  assign w_push_try = w_capture && r_phase;
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  // Output stage refills whenever it is empty or its word is leaving this cycle.
  assign w_fifo_rd  = (r_count != {(AW+1){1'b0}}) && (!r_tvalid || m_axis_tready);
  // A read in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_push     = w_push_try && (!w_full || w_fifo_rd);
  assign w_drop     = w_push_try && !w_push;
  assign w_cnt_inc  = r_word_cnt + CW'(1);
  assign w_is_last  = (w_cnt_inc == r_size_words);
  assign w_last_hs  = r_tvalid && m_axis_tready && r_tlast;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next_state = S_CAPTURE;
        else            w_next_state = S_IDLE;
      end
      S_CAPTURE: begin
        if (w_push && w_is_last) w_next_state = S_DRAIN;
        else                     w_next_state = S_CAPTURE;
      end
      S_DRAIN: begin
        if (w_last_hs) w_next_state = S_IDLE;
        else           w_next_state = S_DRAIN;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    if (r_state != S_IDLE) w_busy = 1'b1;
    else                   w_busy = 1'b0;
  end

  // Packet setup, half-word pairing and pushed-word counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_size_words <= {CW{1'b0}};
      r_word_cnt   <= {CW{1'b0}};
      r_phase      <= 1'b0;
      r_low        <= 16'd0;
    end else if (w_start_ok) begin
      r_size_words <= packet_size[SIZE_WIDTH-1:2];
      r_word_cnt   <= {CW{1'b0}};
      r_phase      <= 1'b0;
    end else if (w_capture) begin
      if (!r_phase) begin
        r_low   <= w_sample;
        r_phase <= 1'b1;
      end else begin
        r_phase <= 1'b0;
        // Dropped words do not count, so the packet keeps its programmed length.
        if (w_push) r_word_cnt <= w_cnt_inc;
      end
    end
  end

  // Sticky overflow and registered done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_start_ok)  r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
      r_done <= (r_state == S_DRAIN) && w_last_hs;
    end
  end

  // FIFO storage {last, data}; contents need no reset since pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_is_last, w_sample, r_low};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push)    r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_fifo_rd};
    end
  end

  // Registered AXIS output stage; holds its word while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tvalid <= 1'b0;
      r_tdata  <= 32'd0;
      r_tlast  <= 1'b0;
    end else if (w_fifo_rd) begin
      r_tvalid <= 1'b1;
      {r_tlast, r_tdata} <= r_mem[r_rd_ptr];
    end else if (m_axis_tready) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  assign busy          = w_busy;
  assign done          = r_done;
  assign overflow      = r_overflow;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = 4'hF;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

endmodule
